// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - segment patterns and display mode type for the lock display
package lock_pkg;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_N     = 7'h2B;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    MSG    = 2'd1,
    LOCKED = 2'd2
  } mode_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - nibble to active-low 7-segment pattern
module seg7_decode
  import lock_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hF: seg = SEG_BLANK;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/lock_display_scan.sv
// rtl/lock_display_scan.sv - 4-digit multiplexed display of lock code and status
module lock_display_scan
  import lock_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000,
  parameter int MSG_CYCLES = 100000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        OPEN,
  input  logic        LOCK,
  input  logic        SAVE_LIGHT,
  input  logic        CHANGE,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SCAN_W  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int BLINK_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;
  localparam int MSG_W   = (MSG_CYCLES > 1) ? $clog2(MSG_CYCLES) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [MSG_W-1:0]   MSG_LOAD   = MSG_W'(MSG_CYCLES - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_blank;
  logic [MSG_W-1:0]   msg_cnt, msg_cnt_next;
  logic               open_q;
  mode_t              mode, mode_next;

  logic               open_rise;
  logic [3:0]         nibble;
  logic [6:0]         data_seg;
  logic [3:0]         an_next;
  logic [6:0]         seg_next;
  logic               dp_next;

  assign open_rise = OPEN & ~open_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode    <= NORMAL;
      msg_cnt <= '0;
    end else begin
      mode    <= mode_next;
      msg_cnt <= msg_cnt_next;
    end
  end

  // Lockout dominates; an OPEN edge may start or retrigger the message from any unlocked mode
  always_comb begin
    mode_next    = mode;
    msg_cnt_next = msg_cnt;
    if (LOCK) begin
      mode_next    = LOCKED;
      msg_cnt_next = '0;
    end else if (open_rise) begin
      mode_next    = MSG;
      msg_cnt_next = MSG_LOAD;
    end else if (mode == MSG) begin
      if (msg_cnt == '0) begin
        mode_next = NORMAL;
      end else begin
        msg_cnt_next = msg_cnt - MSG_W'(1);
      end
    end else begin
      mode_next = NORMAL;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt    <= '0;
      digit_idx   <= 2'd0;
      blink_cnt   <= '0;
      blink_blank <= 1'b0;
      open_q      <= 1'b0;
    end else begin
      open_q <= OPEN;
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      // Held at zero/visible outside lockout so every lockout starts with a visible half-period
      if (LOCK && mode == LOCKED) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_blank <= ~blink_blank;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end else begin
        blink_cnt   <= '0;
        blink_blank <= 1'b0;
      end
    end
  end

  assign nibble = data[{digit_idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (data_seg)
  );

  always_comb begin
    an_next  = ~(4'b0001 << digit_idx);
    seg_next = data_seg;
    dp_next  = 1'b1;
    if (digit_idx == 2'd0) dp_next = ~SAVE_LIGHT;
    if (digit_idx == 2'd3) dp_next = ~CHANGE;
    if (mode == LOCKED && blink_blank) begin
      an_next  = 4'b1111;
      seg_next = SEG_BLANK;
      dp_next  = 1'b1;
    end else if (mode == MSG) begin
      dp_next = 1'b1;
      case (digit_idx)
        2'd3:    seg_next = SEG_O;
        2'd2:    seg_next = SEG_P;
        2'd1:    seg_next = SEG_E;
        default: seg_next = SEG_N;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_lock_display_scan.sv
// tb/tb_lock_display_scan.sv - scoreboard bench for lock_display_scan
module tb_lock_display_scan;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        OPEN = 1'b0;
  logic        LOCK = 1'b0;
  logic        SAVE_LIGHT = 1'b0;
  logic        CHANGE = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  lock_display_scan #(
    .SCAN_DIV   (4),
    .BLINK_DIV  (16),
    .MSG_CYCLES (64)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data       (data),
    .OPEN       (OPEN),
    .LOCK       (LOCK),
    .SAVE_LIGHT (SAVE_LIGHT),
    .CHANGE     (CHANGE),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       chk;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         tag;
  } exp_t;

  localparam int T_RST = 0, T_SCAN = 1, T_DEC = 2, T_DP = 3, T_MSG = 4, T_LOCK = 5, T_UNLK = 6;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Edges since final reset release, plus hand-placed display windows in edge numbers
  int n = 0;
  int glyph_from = 0, glyph_to = -1;
  int lock_from = 0, lock_to = -1;
  int cur_tag = T_SCAN;

  function automatic string tag_name(input int t);
    case (t)
      T_RST:   return "reset";
      T_SCAN:  return "scan_1234";
      T_DEC:   return "decode_fa90";
      T_DP:    return "dp_indicators";
      T_MSG:   return "open_msg";
      T_LOCK:  return "lockout";
      default: return "unlock_msg";
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hF: return 7'h7F;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      3: return 7'h40;
      2: return 7'h0C;
      1: return 7'h06;
      default: return 7'h2B;
    endcase
  endfunction

  task automatic rst_step(input logic chk);
    exp_t e;
    e.chk = chk; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.tag = T_RST;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic step();
    exp_t       e;
    int         j;
    int         d;
    logic [15:0] sh;
    logic [3:0] nib;
    j  = n + 1;
    d  = (n / 4) % 4;
    sh = data >> (4 * d);
    nib = sh[3:0];
    e.chk = 1'b1;
    e.tag = cur_tag;
    e.an  = 4'hF & ~(4'b0001 << d);
    e.seg = ref_seg(nib);
    e.dp  = (d == 0) ? ~SAVE_LIGHT : (d == 3) ? ~CHANGE : 1'b1;
    if (j >= lock_from && j <= lock_to) begin
      if (((j - lock_from) / 16) % 2 == 1) begin
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      end
    end else if (j >= glyph_from && j <= glyph_to) begin
      e.seg = ref_glyph(d);
      e.dp  = 1'b1;
    end
    sb.push_back(e);
    @(posedge clock);
    n++;
    @(negedge clock);
  endtask

  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.chk) begin
        checks++;
        if (an !== mon_e.an || seg !== mon_e.seg || dp !== mon_e.dp) begin
          errors++;
          $display("FAIL %s @%0t: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                   tag_name(mon_e.tag), $time, an, seg, dp, mon_e.an, mon_e.seg, mon_e.dp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete, expected completion before 200000");
    $fatal(1);
  end

  initial begin
    repeat (2) rst_step(1'b1);
    reset = 1'b1;
    repeat (6) rst_step(1'b0);
    reset = 1'b0;
    repeat (3) rst_step(1'b1);

    data = 16'h1234;
    reset = 1'b1;
    n = 0;
    cur_tag = T_SCAN;
    repeat (20) step();

    cur_tag = T_DEC;
    data = 16'hFA90;
    repeat (16) step();

    cur_tag = T_DP;
    data = 16'h1234;
    SAVE_LIGHT = 1'b1;
    CHANGE = 1'b1;
    repeat (16) step();

    // OPEN edge at relative cycle 0, falling at 5, retrigger at 40
    cur_tag = T_MSG;
    OPEN = 1'b1;
    glyph_from = n + 2; glyph_to = n + 65;
    step();
    repeat (4) step();
    OPEN = 1'b0;
    repeat (35) step();
    OPEN = 1'b1;
    glyph_to = n + 65;
    step();
    repeat (70) step();

    // Lock during a fresh message, hold 64 edges, then drop LOCK with an OPEN edge
    cur_tag = T_LOCK;
    OPEN = 1'b0;
    step();
    OPEN = 1'b1;
    glyph_from = n + 2; glyph_to = n + 65;
    step();
    repeat (8) step();
    LOCK = 1'b1;
    glyph_to = n + 1;
    lock_from = n + 2; lock_to = n + 65;
    repeat (40) step();
    OPEN = 1'b0;
    repeat (24) step();

    cur_tag = T_UNLK;
    LOCK = 1'b0;
    OPEN = 1'b1;
    glyph_from = n + 2; glyph_to = n + 65;
    step();
    repeat (80) step();

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clock);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
